// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage data-bus master. Runs one request/grant/response
// transaction at a time and stalls the pipeline while it is outstanding.
// Store lanes and byte enables are built in IDLE and latched. Load data is
// formatted in the response cycle.
module dmem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [3:0]        dbus_be_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [DATA_W-1:0] dbus_rdata_i,
  output logic [DATA_W-1:0] load_data_o,
  output logic              load_valid_o,
  output logic              stall_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic                dbus_req_q, dbus_req_d;
  logic                dbus_we_q, dbus_we_d;
  logic [ADDR_W-1:0]   dbus_addr_q, dbus_addr_d;
  logic [3:0]          dbus_be_q, dbus_be_d;
  logic [DATA_W-1:0]   dbus_wdata_q, dbus_wdata_d;

  logic                illegal, misaligned, acc_ok;
  logic [3:0]          be_new;
  logic [DATA_W-1:0]   wdata_new;
  logic                resp;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;

  // Decode legality, alignment, byte enables and lane-replicated store data.
  always_comb begin
    if (mem_we_i) illegal = (funct3_i > 3'b010);
    else          illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    case (funct3_i[1:0])
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = (addr_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    acc_ok = !illegal && !misaligned;
    be_new    = 4'b1111;
    wdata_new = '0;
    if (mem_we_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_new    = 4'b0001 << addr_i[1:0];
          wdata_new = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{wdata_i[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = wdata_i;
        end
      endcase
    end
  end

  // Next-state and latched-field logic; bus fields are cleared once granted
  // so they only read non-zero while the request is presented.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    dbus_req_d   = dbus_req_q;
    dbus_we_d    = dbus_we_q;
    dbus_addr_d  = dbus_addr_q;
    dbus_be_d    = dbus_be_q;
    dbus_wdata_d = dbus_wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_req_i && acc_ok) begin
          state_d      = REQ;
          we_d         = mem_we_i;
          funct3_d     = funct3_i;
          off_d        = addr_i[1:0];
          dbus_req_d   = 1'b1;
          dbus_we_d    = mem_we_i;
          dbus_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
          dbus_be_d    = be_new;
          dbus_wdata_d = wdata_new;
        end
      end
      REQ: begin
        if (dbus_gnt_i) begin
          state_d      = WAIT;
          dbus_req_d   = 1'b0;
          dbus_we_d    = 1'b0;
          dbus_addr_d  = '0;
          dbus_be_d    = '0;
          dbus_wdata_d = '0;
        end
      end
      WAIT: begin
        if (dbus_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-field registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_be_q    <= '0;
      dbus_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      dbus_req_q   <= dbus_req_d;
      dbus_we_q    <= dbus_we_d;
      dbus_addr_q  <= dbus_addr_d;
      dbus_be_q    <= dbus_be_d;
      dbus_wdata_q <= dbus_wdata_d;
    end
  end

  assign dbus_req_o   = dbus_req_q;
  assign dbus_we_o    = dbus_we_q;
  assign dbus_addr_o  = dbus_addr_q;
  assign dbus_be_o    = dbus_be_q;
  assign dbus_wdata_o = dbus_wdata_q;

  assign resp      = (state_q == WAIT) && dbus_rvalid_i;
  assign byte_lane = dbus_rdata_i[{off_q, 3'b000} +: 8];
  assign half_lane = dbus_rdata_i[{off_q[1], 4'b0000} +: 16];

  // Response-cycle outputs: load formatting, stall release and error pulse.
  always_comb begin
    load_valid_o = resp && !we_q;
    load_data_o  = '0;
    if (load_valid_o) begin
      case (funct3_q)
        3'b000:  load_data_o = {{24{byte_lane[7]}}, byte_lane};
        3'b001:  load_data_o = {{16{half_lane[15]}}, half_lane};
        3'b100:  load_data_o = {24'b0, byte_lane};
        3'b101:  load_data_o = {16'b0, half_lane};
        default: load_data_o = dbus_rdata_i;
      endcase
    end
    stall_o = ((state_q == IDLE) && mem_req_i && acc_ok) || (state_q == REQ) ||
              ((state_q == WAIT) && !dbus_rvalid_i);
    err_o   = (state_q == IDLE) && mem_req_i && !acc_ok;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Data-memory access unit for the MEM stage. It consumes the forwarded store data produced by `mem_stage` together with the address and access type from EX/MEM. It runs a request/grant/response transaction on the data bus, generating byte enables and aligned write data for stores. For loads it returns sign- or zero-extended data, and it stalls the pipeline while the transaction is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; fixed at 32 and not otherwise supported.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mem_req_i` input 1: valid load/store in the MEM stage.
- `mem_we_i` input 1: 1 = store, 0 = load.
- `funct3_i` input 3: access type.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `addr_i` input 32: byte address (ALU result).
- `wdata_i` input 32: store data (`mem_data_o` of `mem_stage`).
- `dbus_req_o` output 1: bus request.
- `dbus_we_o` output 1: bus write.
- `dbus_addr_o` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dbus_be_o` output 4: byte enables.
- `dbus_wdata_o` output 32: lane-aligned write data.
- `dbus_gnt_i` input 1: request accepted.
- `dbus_rvalid_i` input 1: response valid; exactly one per granted request, loads and stores alike.
- `dbus_rdata_i` input 32: response data.
- `load_data_o` output 32: formatted load result.
- `load_valid_o` output 1: `load_data_o` valid this cycle.
- `stall_o` output 1: hold IF..MEM this cycle.
- `err_o` output 1: misaligned or illegal access, one-cycle pulse.

## Operation
- **FSM states.**
  - IDLE:
    - On `mem_req_i` with a legal, aligned access, latch `we`, `funct3`, `addr[1:0]`, bus address, byte enables and write data, then go to REQ.
    - On `mem_req_i` with an illegal or misaligned access, assert `err_o`, issue no bus transaction and stay in IDLE.
  - REQ: `dbus_req_o`=1 with the latched fields held stable. On `dbus_gnt_i` go to WAIT; otherwise stay in REQ.
  - WAIT: `dbus_req_o`=0. On `dbus_rvalid_i` go to IDLE.
- **Misaligned access:**
  - LH/LHU/SH with `addr[0]`=1.
  - LW/SW with `addr[1:0]`≠0.
- **Illegal access:**
  - Load `funct3` in {011, 110, 111}.
  - Store `funct3` ≥ 011.
- **Byte enables and write data.**
  - SB: be = `4'b0001<<addr[1:0]`; wdata = `{4{wdata_i[7:0]}}`.
  - SH: be = `addr[1] ? 4'b1100 : 4'b0011`; wdata = `{2{wdata_i[15:0]}}`.
  - SW: be = `4'b1111`; wdata = `wdata_i`.
  - Loads: be = `4'b1111`; wdata = 0.
- **Load formatting.**
  - Formatting uses the latched offset and `funct3`.
  - Byte lane = `rdata[8*off +: 8]`.
  - Halfword lane = `rdata[16*off[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Load result outputs.**
  - `load_valid_o` = WAIT & `dbus_rvalid_i` & !latched_we.
  - `load_data_o` is driven combinationally from `dbus_rdata_i` in that cycle and is 0 at all other times.
- **Stall:** `stall_o` = (IDLE & `mem_req_i` & legal & aligned) | REQ | WAIT | 0 in the response cycle.
  - The expression is forced to 0 whenever WAIT & `dbus_rvalid_i`.
  - The MEM/WB register therefore captures `load_data_o` on the edge ending the response cycle, and the pipeline advances.
- **Ignored bus inputs:**
  - `dbus_gnt_i` outside REQ.
  - `dbus_rvalid_i` outside WAIT.

## Timing
- **Reset:** async reset forces state IDLE and clears all latched fields. Every output then reads 0, including `dbus_*` outputs, `stall_o`, `err_o`, `load_valid_o` and `load_data_o`.
- **Reset mid-transaction:** the unit returns to IDLE and any later gnt/rvalid for the abandoned transaction is ignored.
- **Minimum access is 3 cycles:**
  - C0: IDLE detect, `stall_o`=1.
  - C1: REQ with gnt, `stall_o`=1.
  - C2: WAIT with rvalid, `stall_o`=0, `load_valid_o`=1.
- Each cycle gnt is late adds one REQ cycle; each cycle rvalid is late adds one WAIT cycle.
- Address, byte enables, write data and `we` stay stable from the first REQ cycle through the gnt cycle.
- **Back-to-back accesses:** the next instruction's `mem_req_i` is sampled in IDLE in the cycle after the response. There is no bubble beyond the FSM latency and no overlapping transactions (one outstanding maximum).
- **Error path:** `err_o` and `stall_o`=0 occur in the same cycle as `mem_req_i`, so the instruction leaves MEM after one cycle.
- **Store vs. pipeline input:** `stall_o` is combinational from `mem_req_i` in IDLE. `wdata_i` may change after C0 without affecting the store, because it was latched in C0.

## Test plan
- **SW:** addr 0x104, wdata 0xDEADBEEF, gnt in C1, rvalid in C2.
  - C1: `dbus_addr_o`=0x104, be=1111, wdata=0xDEADBEEF, `dbus_we_o`=1.
  - `stall_o`=1 in C0/C1 and 0 in C2.
  - `load_valid_o` stays 0.
- **SB / SH lane mapping:**
  - SB at 0x103 with wdata 0x000000A5: be=1000, wdata=0xA5A5A5A5.
  - SH at 0x102 with wdata 0x1234: be=1100, wdata=0x12341234.
- **Load extension:** rdata 0x80FF7F01.
  - LB off 1 → 0x0000007F.
  - LB off 2 → 0xFFFFFFFF.
  - LBU off 3 → 0x00000080.
  - LH off 2 → 0xFFFF80FF.
  - LHU off 0 → 0x00007F01.
  - LW → 0x80FF7F01.
- **Wait states:** gnt 3 cycles late and rvalid 2 cycles late.
  - `dbus_req_o` is high for 4 cycles.
  - `stall_o` is high for 1+4+2 cycles, then drops with `load_valid_o`=1.
  - Spurious gnt/rvalid pulses while in IDLE cause no effect.
- **Errors:**
  - LW at 0x102: `err_o`=1 for one cycle, no `dbus_req_o`, `stall_o`=0.
  - SH at 0x101: same response.
  - Load with `funct3`=011: same response.
- **Reset in WAIT:** drop `rst_n` in WAIT, then release it.
  - All outputs read 0 immediately.
  - A late rvalid produces no `load_valid_o`.
  - The next legal access completes normally.
